dec_fpr_wb_arb: RTL and testbench

- Writeback arbiter that sits directly upstream of the FP register file and drives its three write ports (wen0..2 / waddr0..2 / wd0..2).
- Port 0 carries the fixed-latency FMA pipe and port 1 carries the FP load return; neither of these sources can stall.
- Port 2 is shared by the variable-latency FDIV/FSQRT unit and the integer-to-FP move unit. Both use valid/ready handshakes through a small queue.
- The block guarantees that no two write ports target the same FPR in the same cycle.

---
 rtl/dec_fpr_pkg.sv | 19 +
 rtl/dec_fpr_wb_fifo.sv | 51 +++++
 rtl/dec_fpr_wb_arb.sv | 133 +++++++++++++
 tb/tb_dec_fpr_wb_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_fpr_pkg.sv
// Shared types and widths for the FP register file writeback path.
package dec_fpr_pkg;

    localparam int FPR_W  = 64;
    localparam int FPR_AW = 5;

    // One pending FPR write: destination register and the value to write.
    typedef struct packed {
        logic [FPR_AW-1:0] rd;
        logic [FPR_W-1:0]  data;
    } fpr_wb_t;

    // Which port-2 source gets priority when both are presenting a result.
    typedef enum logic {
        RR_DIV = 1'b0,
        RR_MV  = 1'b1
    } rr_sel_e;

endpackage

// File: rtl/dec_fpr_wb_fifo.sv
// Small synchronous FIFO of pending FPR writes feeding write port 2.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dec_fpr_wb_fifo
    import dec_fpr_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic    clk,
    input  logic    rst_l,
    input  logic    push,
    input  fpr_wb_t push_data,
    input  logic    pop,
    input  logic    flush,
    output logic    full,
    output logic    empty,
    output fpr_wb_t head
);

    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    fpr_wb_t               mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // Advance pointers on push/pop; flush discards everything by realigning them.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
    end

endmodule

// File: rtl/dec_fpr_wb_arb.sv
// FPR writeback arbiter. Ports 0 and 1 are registered pass-throughs for the
// FMA pipe and load return; port 2 drains a queue shared by the FDIV/FSQRT
// unit and the int-to-FP move unit, holding its head whenever it would write
// the same FPR as port 0 or port 1 in the same cycle.
module dec_fpr_wb_arb
    import dec_fpr_pkg::*;
#(
    parameter int QDEPTH      = 4,
    parameter int QDEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              fma_valid,
    input  logic [FPR_AW-1:0] fma_rd,
    input  logic [FPR_W-1:0]  fma_data,
    input  logic              ld_valid,
    input  logic [FPR_AW-1:0] ld_rd,
    input  logic [FPR_W-1:0]  ld_data,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [FPR_AW-1:0] div_rd,
    input  logic [FPR_W-1:0]  div_data,
    input  logic              mv_valid,
    output logic              mv_ready,
    input  logic [FPR_AW-1:0] mv_rd,
    input  logic [FPR_W-1:0]  mv_data,
    input  logic              flush,
    output logic              wen0,
    output logic              wen1,
    output logic              wen2,
    output logic [FPR_AW-1:0] waddr0,
    output logic [FPR_AW-1:0] waddr1,
    output logic [FPR_AW-1:0] waddr2,
    output logic [FPR_W-1:0]  wd0,
    output logic [FPR_W-1:0]  wd1,
    output logic [FPR_W-1:0]  wd2,
    output logic              q_empty,
    output logic              conflict_stall
);

    rr_sel_e rr_sel;
    logic    q_full;
    logic    q_empty_int;
    logic    q_push;
    logic    q_pop;
    logic    can_enq;
    logic    div_push;
    logic    mv_push;
    logic    head_hit;
    fpr_wb_t q_head;
    fpr_wb_t q_push_data;

    // Ready reflects queue space and the grant; a full queue is never bypassed.
    assign can_enq   = !q_full && !flush;
    assign div_ready = can_enq && (!mv_valid  || (rr_sel == RR_DIV));
    assign mv_ready  = can_enq && (!div_valid || (rr_sel == RR_MV));
    assign div_push  = div_valid && div_ready;
    assign mv_push   = mv_valid && mv_ready;
    assign q_push    = div_push || mv_push;

    // The head may only issue if neither fixed-latency port writes its FPR now.
    assign head_hit       = (fma_valid && (fma_rd == q_head.rd)) ||
                            (ld_valid  && (ld_rd  == q_head.rd));
    assign conflict_stall = !q_empty_int && head_hit;
    assign q_pop          = !q_empty_int && !head_hit && !flush;
    assign q_empty        = q_empty_int;

    // Select the payload of whichever source won the enqueue grant.
    always_comb begin
        q_push_data = '{rd: mv_rd, data: mv_data};
        if (div_push)
            q_push_data = '{rd: div_rd, data: div_data};
    end

    dec_fpr_wb_fifo #(
        .DEPTH      (QDEPTH),
        .DEPTH_LOG2 (QDEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (flush),
        .full      (q_full),
        .empty     (q_empty_int),
        .head      (q_head)
    );

    // Hand priority to the other source after every accepted enqueue.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)
            rr_sel <= RR_DIV;
        else if (q_push)
            rr_sel <= (rr_sel == RR_DIV) ? RR_MV : RR_DIV;
    end

    // Register all three write ports; port 2 only loads a new entry when it issues.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wen0   <= 1'b0;
            wen1   <= 1'b0;
            wen2   <= 1'b0;
            waddr0 <= '0;
            waddr1 <= '0;
            waddr2 <= '0;
            wd0    <= '0;
            wd1    <= '0;
            wd2    <= '0;
        end else begin
            wen0   <= fma_valid;
            waddr0 <= fma_rd;
            wd0    <= fma_data;
            wen1   <= ld_valid;
            waddr1 <= ld_rd;
            wd1    <= ld_data;
            wen2   <= q_pop;
            if (q_pop) begin
                waddr2 <= q_head.rd;
                wd2    <= q_head.data;
            end
        end
    end

`ifdef ASSERT_ON
    // Sources on ports 0 and 1 must never target the same FPR in one cycle.
    a_no_port01_collision : assert property (
        @(posedge clk) disable iff (!rst_l)
        !(fma_valid && ld_valid && (fma_rd == ld_rd))
    );
`endif

endmodule

// File: tb/tb_dec_fpr_wb_arb.sv
// Directed bench for the FPR writeback arbiter: pass-through, round-robin,
// full queue, head collision, flush and asynchronous reset.
module tb_dec_fpr_wb_arb;

    logic        clk;
    logic        rst_l;
    logic        fma_valid;
    logic [4:0]  fma_rd;
    logic [63:0] fma_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        div_valid;
    logic        div_ready;
    logic [4:0]  div_rd;
    logic [63:0] div_data;
    logic        mv_valid;
    logic        mv_ready;
    logic [4:0]  mv_rd;
    logic [63:0] mv_data;
    logic        flush;
    logic        wen0;
    logic        wen1;
    logic        wen2;
    logic [4:0]  waddr0;
    logic [4:0]  waddr1;
    logic [4:0]  waddr2;
    logic [63:0] wd0;
    logic [63:0] wd1;
    logic [63:0] wd2;
    logic        q_empty;
    logic        conflict_stall;

    int checkCount = 0;
    int passCount  = 0;

    dec_fpr_wb_arb #(
        .QDEPTH      (4),
        .QDEPTH_LOG2 (2)
    ) dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .fma_valid      (fma_valid),
        .fma_rd         (fma_rd),
        .fma_data       (fma_data),
        .ld_valid       (ld_valid),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
        .div_valid      (div_valid),
        .div_ready      (div_ready),
        .div_rd         (div_rd),
        .div_data       (div_data),
        .mv_valid       (mv_valid),
        .mv_ready       (mv_ready),
        .mv_rd          (mv_rd),
        .mv_data        (mv_data),
        .flush          (flush),
        .wen0           (wen0),
        .wen1           (wen1),
        .wen2           (wen2),
        .waddr0         (waddr0),
        .waddr1         (waddr1),
        .waddr2         (waddr2),
        .wd0            (wd0),
        .wd1            (wd1),
        .wd2            (wd2),
        .q_empty        (q_empty),
        .conflict_stall (conflict_stall)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(
        input logic        fv, input logic [4:0] fr, input logic [63:0] fd,
        input logic        lv, input logic [4:0] lr, input logic [63:0] ldd,
        input logic        dv, input logic [4:0] dr, input logic [63:0] dd,
        input logic        mvv, input logic [4:0] mr, input logic [63:0] md,
        input logic        fl);
        fma_valid = fv;  fma_rd = fr; fma_data = fd;
        ld_valid  = lv;  ld_rd  = lr; ld_data  = ldd;
        div_valid = dv;  div_rd = dr; div_data = dd;
        mv_valid  = mvv; mv_rd  = mr; mv_data  = md;
        flush     = fl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_l = 1'b0;
        idle();
        checkOutput("reset_wen0",   64'(wen0), 64'd0);
        checkOutput("reset_wen1",   64'(wen1), 64'd0);
        checkOutput("reset_wen2",   64'(wen2), 64'd0);
        checkOutput("reset_waddr2", 64'(waddr2), 64'd0);
        checkOutput("reset_wd0",    wd0, 64'd0);
        checkOutput("reset_qempty", 64'(q_empty), 64'd1);
        checkOutput("reset_stall",  64'(conflict_stall), 64'd0);
        tick();
        tick();
        rst_l = 1'b1;
        tick();

        // Pass-through on ports 0 and 1.
        applyStimulus(1, 3, 64'h1111, 1, 7, 64'h2222, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        checkOutput("pt_wen0",   64'(wen0), 64'd1);
        checkOutput("pt_waddr0", 64'(waddr0), 64'd3);
        checkOutput("pt_wd0",    wd0, 64'h1111);
        checkOutput("pt_wen1",   64'(wen1), 64'd1);
        checkOutput("pt_waddr1", 64'(waddr1), 64'd7);
        checkOutput("pt_wd1",    wd1, 64'h2222);
        checkOutput("pt_wen2",   64'(wen2), 64'd0);
        tick();
        checkOutput("pt_wen0_off", 64'(wen0), 64'd0);

        // Round-robin: both sources valid for four cycles, grants div, mv, div, mv.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 64'hD1, 1, 11, 64'hA1, 0);
        checkOutput("rr0_div_ready", 64'(div_ready), 64'd1);
        checkOutput("rr0_mv_ready",  64'(mv_ready), 64'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 64'hD2, 1, 11, 64'hA1, 0);
        checkOutput("rr1_div_ready", 64'(div_ready), 64'd0);
        checkOutput("rr1_mv_ready",  64'(mv_ready), 64'd1);
        checkOutput("rr1_wen2",      64'(wen2), 64'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 64'hD2, 1, 11, 64'hA2, 0);
        checkOutput("rr2_div_ready", 64'(div_ready), 64'd1);
        checkOutput("rr2_wen2",      64'(wen2), 64'd1);
        checkOutput("rr2_waddr2",    64'(waddr2), 64'd10);
        checkOutput("rr2_wd2",       wd2, 64'hD1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 10, 64'hD3, 1, 11, 64'hA2, 0);
        checkOutput("rr3_mv_ready",  64'(mv_ready), 64'd1);
        checkOutput("rr3_waddr2",    64'(waddr2), 64'd11);
        checkOutput("rr3_wd2",       wd2, 64'hA1);
        tick();
        idle();
        checkOutput("rr4_waddr2",    64'(waddr2), 64'd10);
        checkOutput("rr4_wd2",       wd2, 64'hD2);
        tick();
        checkOutput("rr5_wen2",      64'(wen2), 64'd1);
        checkOutput("rr5_waddr2",    64'(waddr2), 64'd11);
        checkOutput("rr5_wd2",       wd2, 64'hA2);
        tick();
        checkOutput("rr6_wen2",      64'(wen2), 64'd0);
        checkOutput("rr6_qempty",    64'(q_empty), 64'd1);

        // Head collision with the FMA port holds the entry for one cycle.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 5, 64'h55, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 5, 64'hF5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("col_stall", 64'(conflict_stall), 64'd1);
        tick();
        idle();
        checkOutput("col_wen2",   64'(wen2), 64'd0);
        checkOutput("col_wen0",   64'(wen0), 64'd1);
        checkOutput("col_waddr0", 64'(waddr0), 64'd5);
        checkOutput("col_stall_clear", 64'(conflict_stall), 64'd0);
        tick();
        checkOutput("col_rel_wen2",   64'(wen2), 64'd1);
        checkOutput("col_rel_waddr2", 64'(waddr2), 64'd5);
        checkOutput("col_rel_wd2",    wd2, 64'h55);
        tick();

        // Fill the queue behind a colliding head, then drain it.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 20, 0, 0, 0, 0, 1, 20, 64'hE0 + 64'(i), 0, 0, 0, 0);
            checkOutput("full_fill_ready", 64'(div_ready), 64'd1);
            tick();
        end
        applyStimulus(1, 20, 0, 0, 0, 0, 1, 20, 64'hEE, 1, 21, 64'hEF, 0);
        checkOutput("full_div_ready", 64'(div_ready), 64'd0);
        checkOutput("full_mv_ready",  64'(mv_ready), 64'd0);
        checkOutput("full_stall",     64'(conflict_stall), 64'd1);
        checkOutput("full_wen2",      64'(wen2), 64'd0);
        tick();
        idle();
        checkOutput("full_nobypass_ready", 64'(div_ready), 64'd0);
        tick();
        checkOutput("drain0_ready", 64'(div_ready), 64'd1);
        checkOutput("drain0_wen2",  64'(wen2), 64'd1);
        checkOutput("drain0_wd2",   wd2, 64'hE0);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput("drain_wen2", 64'(wen2), 64'd1);
            checkOutput("drain_wd2",  wd2, 64'hE0 + 64'(i));
        end
        tick();
        checkOutput("drain_done_wen2", 64'(wen2), 64'd0);

        // Flush three queued entries.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 9, 0, 0, 0, 0, 1, 9, 64'hB0 + 64'(i), 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 64'hBB, 1, 8, 64'hBC, 1);
        checkOutput("flush_div_ready", 64'(div_ready), 64'd0);
        checkOutput("flush_mv_ready",  64'(mv_ready), 64'd0);
        checkOutput("flush_pre_qempty", 64'(q_empty), 64'd0);
        tick();
        idle();
        checkOutput("flush_qempty", 64'(q_empty), 64'd1);
        checkOutput("flush_wen2",   64'(wen2), 64'd0);
        tick();
        checkOutput("flush_wen2_after", 64'(wen2), 64'd0);

        // Asynchronous reset in the middle of a drain.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 64'hC0, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 1, 64'hF1, 0, 0, 0, 1, 13, 64'hC1, 0, 0, 0, 0);
        tick();
        idle();
        checkOutput("ar_pre_wen2",   64'(wen2), 64'd1);
        checkOutput("ar_pre_waddr2", 64'(waddr2), 64'd12);
        checkOutput("ar_pre_wen0",   64'(wen0), 64'd1);
        #2;
        rst_l = 1'b0;
        #1;
        checkOutput("ar_wen0",   64'(wen0), 64'd0);
        checkOutput("ar_wen2",   64'(wen2), 64'd0);
        checkOutput("ar_waddr2", 64'(waddr2), 64'd0);
        checkOutput("ar_qempty", 64'(q_empty), 64'd1);
        #1;
        rst_l = 1'b1;
        tick();
        checkOutput("ar_post_wen2", 64'(wen2), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 14, 64'h77, 0, 0, 0, 0);
        checkOutput("ar_push_ready", 64'(div_ready), 64'd1);
        tick();
        idle();
        checkOutput("ar_n1_wen2", 64'(wen2), 64'd0);
        tick();
        checkOutput("ar_n2_wen2",   64'(wen2), 64'd1);
        checkOutput("ar_n2_waddr2", 64'(waddr2), 64'd14);
        checkOutput("ar_n2_wd2",    wd2, 64'h77);
        tick();
        checkOutput("ar_end_wen2",   64'(wen2), 64'd0);
        checkOutput("ar_end_qempty", 64'(q_empty), 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
